dram_rr_arbiter: RTL and testbench

- Sequences ownership of the single shared DRAM/MMIO bus port among NCORES cores.
- Replaces the fixed grant-toggle scheme with request-driven round-robin. Features: per-owner transaction quantum, drain-before-switch, atomic lock hold and a settle gap.
- Sits between the per-core bus ports and the bus mux. It drives the grant index used by the mux and the per-core busy overrides.

---
 rtl/dram_rr_arbiter_pkg.sv | 19 +
 rtl/dram_rr_arbiter_rr_next_picker.sv | 31 +++
 rtl/dram_rr_arbiter.sv | 116 +++++++++++
 tb/tb_dram_rr_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_rr_arbiter_pkg.sv
// Shared definitions for the DRAM/MMIO bus round-robin arbiter.
// State encodings are fixed so they can be probed by name in debug captures.
package dram_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_OWN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_SETTLE = 2'd3
    } arb_state_e;

    localparam int NCORES_DEF  = 2;
    localparam int GRANT_W_DEF = $clog2(NCORES_DEF);

    // Wide enough for QUANTUM up to 255 and GAP up to 15.
    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

endpackage

// File: rtl/dram_rr_arbiter_rr_next_picker.sv
// Combinational round-robin picker: first requester after the current index,
// found by rotating the request vector, priority-encoding, and rotating back.
module rr_next_picker #(
    parameter int NCORES  = 2,
    parameter int GRANT_W = $clog2(NCORES)
) (
    input  logic [NCORES-1:0]  req,
    input  logic [GRANT_W-1:0] cur,
    output logic [GRANT_W-1:0] next_id,
    output logic               found
);

    logic [NCORES-1:0]  rot;
    logic [GRANT_W-1:0] off;

    always_comb begin
        rot = '0;
        // rot[0] is the core right after cur; NCORES is a power of two so
        // the index wraps by truncation.
        for (int i = 0; i < NCORES; i++) begin
            rot[i] = req[cur + GRANT_W'(i + 1)];
        end
        off = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (rot[i]) off = GRANT_W'(i);
        end
        next_id = cur + off + GRANT_W'(1);
        found   = |req;
    end

endmodule

// File: rtl/dram_rr_arbiter.sv
// Request-driven round-robin owner of the shared DRAM/MMIO bus port, with a
// per-owner transaction quantum, drain-before-switch, atomic lock hold and settle gap.
module dram_rr_arbiter
    import dram_rr_arbiter_pkg::*;
#(
    parameter int NCORES  = NCORES_DEF,
    parameter int QUANTUM = 4,
    parameter int GAP     = 1
) (
    input  logic                      CLK,
    input  logic                      RST_X,
    input  logic [NCORES-1:0]         i_req,
    input  logic [NCORES-1:0]         i_lock,
    input  logic                      i_start,
    input  logic                      i_dram_busy,
    output logic [$clog2(NCORES)-1:0] o_grant_id,
    output logic [NCORES-1:0]         o_grant,
    output logic [NCORES-1:0]         o_busy_mask,
    output logic                      o_switch,
    output logic                      o_err
);

    localparam int GRANT_W = $clog2(NCORES);

    arb_state_e         state, state_nxt;
    logic [GRANT_W-1:0] owner, owner_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               sw, sw_nxt;
    logic               err, err_nxt;

    logic [NCORES-1:0]  owner_oh;
    logic [GRANT_W-1:0] pick_id;
    logic               pick_found;
    logic               other_pending;
    logic               quantum_hit;
    logic               yield;

    assign owner_oh      = NCORES'(1) << owner;
    assign other_pending = |(i_req & ~owner_oh);
    assign quantum_hit   = (cnt == CNT_W'(QUANTUM));
    assign yield         = other_pending && !i_lock[owner] &&
                           (quantum_hit || !i_req[owner]);

    rr_next_picker #(
        .NCORES  (NCORES),
        .GRANT_W (GRANT_W)
    ) u_picker (
        .req     (i_req),
        .cur     (owner),
        .next_id (pick_id),
        .found   (pick_found)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state   <= ST_OWN;
            owner   <= '0;
            cnt     <= '0;
            gap_cnt <= '0;
            sw      <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
            gap_cnt <= gap_nxt;
            sw      <= sw_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        gap_nxt   = gap_cnt;
        sw_nxt    = 1'b0;
        err_nxt   = err;
        case (state)
            ST_OWN: begin
                if (i_start && !quantum_hit) cnt_nxt = cnt + CNT_W'(1);
                // A launch in the yield cycle may still be in flight, so drain it.
                if (yield) state_nxt = (i_dram_busy || i_start) ? ST_DRAIN : ST_SWITCH;
            end
            ST_DRAIN: begin
                if (i_start) err_nxt = 1'b1;
                if (!i_dram_busy) state_nxt = ST_SWITCH;
            end
            ST_SWITCH: begin
                if (pick_found) owner_nxt = pick_id;
                sw_nxt  = pick_found && (pick_id != owner);
                cnt_nxt = '0;
                if (GAP == 0) begin
                    state_nxt = ST_OWN;
                end else begin
                    state_nxt = ST_SETTLE;
                    gap_nxt   = GAP_W'(GAP - 1);
                end
            end
            ST_SETTLE: begin
                if (gap_cnt == '0) state_nxt = ST_OWN;
                else               gap_nxt   = gap_cnt - GAP_W'(1);
            end
            default: state_nxt = ST_OWN;
        endcase
    end

    // Outputs decode from registered state only.
    assign o_grant_id  = owner;
    assign o_grant     = (state == ST_OWN || state == ST_DRAIN) ? owner_oh : '0;
    assign o_busy_mask = (state == ST_OWN) ? ~owner_oh : '1;
    assign o_switch    = sw;
    assign o_err       = err;

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Scenario bench for dram_rr_arbiter: a 2-core instance (GAP=1) and a 4-core
// instance (GAP=0), checked cycle by cycle through per-instance expectation queues.
module tb_dram_rr_arbiter;

    localparam int OWN = 0;
    localparam int DRN = 1;
    localparam int SWC = 2;
    localparam int STL = 3;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] lock;
        logic       start;
        logic       busy;
        logic [1:0] st;
        logic [1:0] own;
        logic       sw;
        logic       er;
    } step_t;

    logic CLK = 1'b0;
    logic RST_X;
    always #5 CLK = ~CLK;

    logic [1:0] req_a, lock_a, grant_a, mask_a;
    logic       start_a, busy_a, sw_a, err_a;
    logic [0:0] gid_a;
    logic [3:0] req_b, lock_b, grant_b, mask_b;
    logic       start_b, busy_b, sw_b, err_b;
    logic [1:0] gid_b;

    int checks = 0;
    int errors = 0;
    logic [6:0]  sb_a[$];
    logic [11:0] sb_b[$];

    dram_rr_arbiter #(.NCORES(2), .QUANTUM(4), .GAP(1)) dut_a (
        .CLK(CLK), .RST_X(RST_X), .i_req(req_a), .i_lock(lock_a),
        .i_start(start_a), .i_dram_busy(busy_a), .o_grant_id(gid_a),
        .o_grant(grant_a), .o_busy_mask(mask_a), .o_switch(sw_a), .o_err(err_a)
    );

    dram_rr_arbiter #(.NCORES(4), .QUANTUM(4), .GAP(0)) dut_b (
        .CLK(CLK), .RST_X(RST_X), .i_req(req_b), .i_lock(lock_b),
        .i_start(start_b), .i_dram_busy(busy_b), .o_grant_id(gid_b),
        .o_grant(grant_b), .o_busy_mask(mask_b), .o_switch(sw_b), .o_err(err_b)
    );

    function automatic step_t mk(input logic [3:0] req, input logic [3:0] lock,
                                 input logic start, input logic busy,
                                 input int st, input int own, input bit sw, input bit er);
        step_t s;
        s.req = req; s.lock = lock; s.start = start; s.busy = busy;
        s.st = 2'(st); s.own = 2'(own); s.sw = sw; s.er = er;
        return s;
    endfunction

    // Expected {grant_id, grant, busy_mask, switch, err} for the 2-core instance.
    function automatic logic [6:0] ea(input step_t s);
        logic [1:0] oh;
        logic [1:0] g;
        logic [1:0] m;
        oh = 2'b01 << s.own[0];
        g  = (s.st == 2'(OWN) || s.st == 2'(DRN)) ? oh : 2'b00;
        m  = (s.st == 2'(OWN)) ? ~oh : 2'b11;
        return {s.own[0], g, m, s.sw, s.er};
    endfunction

    function automatic logic [11:0] eb(input step_t s);
        logic [3:0] oh;
        logic [3:0] g;
        logic [3:0] m;
        oh = 4'b0001 << s.own;
        g  = (s.st == 2'(OWN) || s.st == 2'(DRN)) ? oh : 4'b0000;
        m  = (s.st == 2'(OWN)) ? ~oh : 4'b1111;
        return {s.own, g, m, s.sw, s.er};
    endfunction

    task automatic idle_inputs();
        req_a = '0; lock_a = '0; start_a = 1'b0; busy_a = 1'b0;
        req_b = '0; lock_b = '0; start_b = 1'b0; busy_b = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        RST_X = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_X = 1'b1;
    endtask

    task automatic test_reset();
        logic [6:0]  ga, xa;
        logic [11:0] gb, xb;
        idle_inputs();
        RST_X = 1'b0;
        #3;
        sb_a.push_back(ea(mk(4'h0, 4'h0, 0, 0, OWN, 0, 0, 0)));
        sb_b.push_back(eb(mk(4'h0, 4'h0, 0, 0, OWN, 0, 0, 0)));
        ga = {gid_a, grant_a, mask_a, sw_a, err_a};
        gb = {gid_b, grant_b, mask_b, sw_b, err_b};
        xa = sb_a.pop_front();
        xb = sb_b.pop_front();
        checks++;
        if (ga !== xa) begin errors++; $display("FAIL reset_a: got %b want %b", ga, xa); end
        checks++;
        if (gb !== xb) begin errors++; $display("FAIL reset_b: got %b want %b", gb, xb); end
        @(posedge CLK); #1;
        RST_X = 1'b1;
        // No requester anywhere: core 0 simply keeps the bus.
        sb_a.push_back(ea(mk(4'h0, 4'h0, 0, 0, OWN, 0, 0, 0)));
        @(posedge CLK); #1;
        ga = {gid_a, grant_a, mask_a, sw_a, err_a};
        xa = sb_a.pop_front();
        checks++;
        if (ga !== xa) begin errors++; $display("FAIL reset_idle_a: got %b want %b", ga, xa); end
    endtask

    task automatic test_single_owner();
        step_t s[$];
        logic [6:0] got, xp;
        reset_dut();
        for (int i = 0; i < 20; i++) s.push_back(mk(4'b0001, 4'h0, (i % 2) == 0, 0, OWN, 0, 0, 0));
        foreach (s[i]) begin
            req_a = s[i].req[1:0]; lock_a = s[i].lock[1:0]; start_a = s[i].start; busy_a = s[i].busy;
            sb_a.push_back(ea(s[i]));
            @(posedge CLK); #1;
            got = {gid_a, grant_a, mask_a, sw_a, err_a};
            xp  = sb_a.pop_front();
            checks++;
            if (got !== xp) begin errors++; $display("FAIL single_owner step %0d: got %b want %b", i, got, xp); end
        end
        idle_inputs();
    endtask

    task automatic test_quantum();
        step_t s[$];
        logic [6:0] got, xp;
        reset_dut();
        for (int i = 0; i < 4; i++) s.push_back(mk(4'b0011, 4'h0, 1, 0, OWN, 0, 0, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, SWC, 0, 0, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, STL, 1, 1, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, OWN, 1, 0, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, OWN, 1, 0, 0));
        foreach (s[i]) begin
            req_a = s[i].req[1:0]; lock_a = s[i].lock[1:0]; start_a = s[i].start; busy_a = s[i].busy;
            sb_a.push_back(ea(s[i]));
            @(posedge CLK); #1;
            got = {gid_a, grant_a, mask_a, sw_a, err_a};
            xp  = sb_a.pop_front();
            checks++;
            if (got !== xp) begin errors++; $display("FAIL quantum step %0d: got %b want %b", i, got, xp); end
        end
        idle_inputs();
    endtask

    task automatic test_drain();
        step_t s[$];
        logic [6:0] got, xp;
        reset_dut();
        s.push_back(mk(4'b0010, 4'h0, 0, 1, DRN, 0, 0, 0));
        s.push_back(mk(4'b0010, 4'h0, 0, 1, DRN, 0, 0, 0));
        s.push_back(mk(4'b0010, 4'b0001, 0, 1, DRN, 0, 0, 0));
        s.push_back(mk(4'b0010, 4'h0, 0, 1, DRN, 0, 0, 0));
        s.push_back(mk(4'b0010, 4'h0, 0, 1, DRN, 0, 0, 0));
        s.push_back(mk(4'b0010, 4'h0, 0, 0, SWC, 0, 0, 0));
        s.push_back(mk(4'b0010, 4'h0, 0, 0, STL, 1, 1, 0));
        s.push_back(mk(4'b0000, 4'h0, 0, 0, OWN, 1, 0, 0));
        s.push_back(mk(4'b0000, 4'h0, 0, 0, OWN, 1, 0, 0));
        foreach (s[i]) begin
            req_a = s[i].req[1:0]; lock_a = s[i].lock[1:0]; start_a = s[i].start; busy_a = s[i].busy;
            sb_a.push_back(ea(s[i]));
            @(posedge CLK); #1;
            got = {gid_a, grant_a, mask_a, sw_a, err_a};
            xp  = sb_a.pop_front();
            checks++;
            if (got !== xp) begin errors++; $display("FAIL drain step %0d: got %b want %b", i, got, xp); end
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        step_t s[$];
        logic [6:0] got, xp;
        reset_dut();
        for (int i = 0; i < 4; i++) s.push_back(mk(4'b0001, 4'b0001, 1, 0, OWN, 0, 0, 0));
        for (int i = 0; i < 5; i++) s.push_back(mk(4'b0011, 4'b0001, 0, 0, OWN, 0, 0, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, SWC, 0, 0, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, STL, 1, 1, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, OWN, 1, 0, 0));
        foreach (s[i]) begin
            req_a = s[i].req[1:0]; lock_a = s[i].lock[1:0]; start_a = s[i].start; busy_a = s[i].busy;
            sb_a.push_back(ea(s[i]));
            @(posedge CLK); #1;
            got = {gid_a, grant_a, mask_a, sw_a, err_a};
            xp  = sb_a.pop_front();
            checks++;
            if (got !== xp) begin errors++; $display("FAIL lock step %0d: got %b want %b", i, got, xp); end
        end
        idle_inputs();
    endtask

    task automatic test_err_and_async_reset();
        step_t s[$];
        logic [6:0] got, xp;
        reset_dut();
        s.push_back(mk(4'b0010, 4'h0, 0, 1, DRN, 0, 0, 0));
        s.push_back(mk(4'b0010, 4'h0, 1, 1, DRN, 0, 0, 1));
        s.push_back(mk(4'b0010, 4'h0, 0, 1, DRN, 0, 0, 1));
        s.push_back(mk(4'b0010, 4'h0, 0, 0, SWC, 0, 0, 1));
        s.push_back(mk(4'b0010, 4'h0, 0, 0, STL, 1, 1, 1));
        s.push_back(mk(4'b0010, 4'h0, 0, 0, OWN, 1, 0, 1));
        s.push_back(mk(4'b0001, 4'h0, 0, 1, DRN, 1, 0, 1));
        foreach (s[i]) begin
            req_a = s[i].req[1:0]; lock_a = s[i].lock[1:0]; start_a = s[i].start; busy_a = s[i].busy;
            sb_a.push_back(ea(s[i]));
            @(posedge CLK); #1;
            got = {gid_a, grant_a, mask_a, sw_a, err_a};
            xp  = sb_a.pop_front();
            checks++;
            if (got !== xp) begin errors++; $display("FAIL err step %0d: got %b want %b", i, got, xp); end
        end
        // Asynchronous reset in the middle of DRAIN, no clock edge in between.
        RST_X = 1'b0;
        sb_a.push_back(ea(mk(4'h0, 4'h0, 0, 0, OWN, 0, 0, 0)));
        #2;
        got = {gid_a, grant_a, mask_a, sw_a, err_a};
        xp  = sb_a.pop_front();
        checks++;
        if (got !== xp) begin errors++; $display("FAIL async_reset: got %b want %b", got, xp); end
        idle_inputs();
        @(posedge CLK); #1;
        RST_X = 1'b1;
    endtask

    task automatic test_wrap_4core();
        step_t s[$];
        logic [11:0] got, xp;
        reset_dut();
        s.push_back(mk(4'b0100, 4'h0, 0, 0, SWC, 0, 0, 0));
        s.push_back(mk(4'b0100, 4'h0, 0, 0, OWN, 2, 1, 0));
        s.push_back(mk(4'b0011, 4'h0, 1, 0, DRN, 2, 0, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, SWC, 2, 0, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, OWN, 0, 1, 0));
        for (int i = 0; i < 4; i++) s.push_back(mk(4'b0011, 4'h0, 1, 0, OWN, 0, 0, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, SWC, 0, 0, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, OWN, 1, 1, 0));
        s.push_back(mk(4'b0011, 4'h0, 0, 0, OWN, 1, 0, 0));
        foreach (s[i]) begin
            req_b = s[i].req; lock_b = s[i].lock; start_b = s[i].start; busy_b = s[i].busy;
            sb_b.push_back(eb(s[i]));
            @(posedge CLK); #1;
            got = {gid_b, grant_b, mask_b, sw_b, err_b};
            xp  = sb_b.pop_front();
            checks++;
            if (got !== xp) begin errors++; $display("FAIL wrap4 step %0d: got %b want %b", i, got, xp); end
        end
        idle_inputs();
    endtask

    initial begin
        RST_X = 1'b0;
        idle_inputs();
        test_reset();
        test_single_owner();
        test_quantum();
        test_drain();
        test_lock();
        test_err_and_async_reset();
        test_wrap_4core();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
